// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready,
// one bit per clock out, with a one-word holding register for gapless streaming.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    input  logic             i_ser_en,
    output logic             o_out_bit,
    output logic             o_out_valid,
    output logic             o_out_last,
    output logic             o_busy,
    output logic [15:0]      o_word_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic [15:0]      r_word_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic [WIDTH-1:0] w_shifted;

    // Ready is forced low during reset so no word is taken while clearing.
    assign o_din_ready = !r_hold_full && !i_rst;
    assign w_accept    = i_din_valid && o_din_ready;
    assign w_last      = (r_cnt == LAST_IDX);
    assign w_bit       = (MSB_FIRST != 0) ? r_sreg[WIDTH-1] : r_sreg[0];
    assign w_shifted   = (MSB_FIRST != 0) ? {r_sreg[WIDTH-2:0], 1'b0}
                                          : {1'b0, r_sreg[WIDTH-1:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_word_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_hold      <= i_din;
                r_hold_full <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        r_sreg      <= r_hold;
                        r_hold_full <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (i_ser_en) begin
                        if (!w_last) begin
                            r_sreg <= w_shifted;
                            r_cnt  <= r_cnt + 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 16'd1;
                            // Reload straight from hold to keep the line gapless.
                            if (r_hold_full) begin
                                r_sreg      <= r_hold;
                                r_hold_full <= 1'b0;
                                r_cnt       <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_out_valid = (r_state == ST_SHIFT) && i_ser_en;
    assign o_out_bit   = o_out_valid ? w_bit : IDLE_BIT;
    assign o_out_last  = o_out_valid && w_last;
    assign o_busy      = (r_state == ST_SHIFT) || r_hold_full;
    assign o_word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first/idle-0 instance and an
// LSB-first/idle-1 instance share one stimulus stream.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       ser_en = 1'b0;

    logic        a_ready, a_bit, a_valid, a_last, a_busy;
    logic [15:0] a_wcnt;
    logic        b_ready, b_bit, b_valid, b_last, b_busy;
    logic [15:0] b_wcnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic va[64], ba[64], la[64], ra[64], vb[64], bb[64];
    int a_nv, a_first, a_lastv, a_nlast, a_nrdylo, a_idlebad, a_det;
    int b_nv, b_idlebad;
    logic [31:0] a_seq, b_seq;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_msb (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid),
        .o_din_ready(a_ready), .i_ser_en(ser_en), .o_out_bit(a_bit),
        .o_out_valid(a_valid), .o_out_last(a_last), .o_busy(a_busy),
        .o_word_cnt(a_wcnt)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) u_lsb (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid),
        .o_din_ready(b_ready), .i_ser_en(ser_en), .o_out_bit(b_bit),
        .o_out_valid(b_valid), .o_out_last(b_last), .o_busy(b_busy),
        .o_word_cnt(b_wcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        ser_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives up to two words with the bench's own handshake bookkeeping,
    // records both instances' outputs per cycle and summarises them.
    task automatic run(input int nw, input logic [7:0] w0, input logic [7:0] w1,
                       input int ncyc, input int stall_at);
        int   qi = 0;
        bit   pend = 1'b0;
        int   nb = 0;
        int   st = 0;
        logic [2:0] h = 3'b000;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (pend) qi++;
            din_valid = (qi < nw);
            din = (qi == 0) ? w0 : w1;
            ser_en = 1'b1;
            if (nb == stall_at && st < 3) begin
                ser_en = 1'b0;
                st++;
            end
            #1;
            va[c] = a_valid; ba[c] = a_bit; la[c] = a_last; ra[c] = a_ready;
            vb[c] = b_valid; bb[c] = b_bit;
            if (a_valid) nb++;
            pend = din_valid && a_ready;
        end
        din_valid = 1'b0;
        a_nv = 0; a_first = -1; a_lastv = -1; a_nlast = 0; a_nrdylo = 0;
        a_idlebad = 0; a_det = 0; a_seq = '0;
        b_nv = 0; b_idlebad = 0; b_seq = '0;
        for (int i = 0; i < ncyc; i++) begin
            if (va[i]) begin
                a_nv++;
                if (a_first < 0) a_first = i;
                a_lastv = i;
                a_seq = {a_seq[30:0], ba[i]};
                h = {h[1:0], ba[i]};
                if (h == 3'b110) a_det++;
            end else if (ba[i] !== 1'b0) begin
                a_idlebad++;
            end
            if (la[i]) a_nlast++;
            if (!ra[i]) a_nrdylo++;
            if (vb[i]) begin
                b_nv++;
                b_seq = {b_seq[30:0], bb[i]};
            end else if (bb[i] !== 1'b1) begin
                b_idlebad++;
            end
        end
    endtask

    function automatic int at(input int base, input int off);
        return (base < 0) ? 0 : base + off;
    endfunction

    initial begin
        @(negedge clk); #1;
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_bit", a_bit, 1'b0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_wcnt", a_wcnt, 16'd0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_lsb_bit", b_bit, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", a_ready, 1'b1);

        do_reset();
        run(1, 8'b1101_1000, 8'h00, 12, -1);
        chk("one_latency", a_first, 2);
        chk("one_nvalid", a_nv, 8);
        chk("one_bits", a_seq[7:0], 8'hD8);
        chk("one_nlast", a_nlast, 1);
        chk("one_lastpos", la[at(a_first, 7)], 1'b1);
        chk("one_det110", a_det, 2);
        chk("one_idle", a_idlebad, 0);
        chk("one_wcnt", a_wcnt, 16'd1);
        chk("one_busy", a_busy, 1'b0);

        do_reset();
        run(2, 8'hA5, 8'h3C, 20, -1);
        chk("b2b_nvalid", a_nv, 16);
        chk("b2b_span", a_lastv - a_first + 1, 16);
        chk("b2b_bits", a_seq[15:0], 16'hA53C);
        chk("b2b_nlast", a_nlast, 2);
        chk("b2b_last1", la[at(a_first, 7)], 1'b1);
        chk("b2b_rdylo", a_nrdylo, 8);
        chk("b2b_rdyup", ra[at(a_first, 8)], 1'b1);
        chk("b2b_wcnt", a_wcnt, 16'd2);

        do_reset();
        run(1, 8'hFF, 8'h00, 16, 2);
        chk("stall_nvalid", a_nv, 8);
        chk("stall_span", a_lastv - a_first + 1, 11);
        chk("stall_bits", a_seq[7:0], 8'hFF);
        chk("stall_idle", a_idlebad, 0);
        chk("stall_lsb_idle", b_idlebad, 0);
        chk("stall_wcnt", a_wcnt, 16'd1);

        do_reset();
        run(1, 8'h01, 8'h00, 12, -1);
        chk("lsb_nvalid", b_nv, 8);
        chk("lsb_bits", b_seq[7:0], 8'h80);
        chk("lsb_idle", b_idlebad, 0);
        chk("lsb_wcnt", b_wcnt, 16'd1);
        chk("lsb_msb_bits", a_seq[7:0], 8'h01);

        do_reset();
        run(2, 8'hF0, 8'h55, 6, -1);
        chk("mid_nvalid", a_nv, 4);
        chk("mid_bits", a_seq[3:0], 4'hF);
        chk("mid_held", a_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_valid", a_valid, 1'b0);
        chk("mid_bit", a_bit, 1'b0);
        chk("mid_busy", a_busy, 1'b0);
        chk("mid_wcnt", a_wcnt, 16'd0);
        chk("mid_ready", a_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", a_ready, 1'b1);
        run(0, 8'h00, 8'h00, 12, -1);
        chk("mid_residual", a_nv, 0);
        chk("mid_lsb_resid", b_nv, 0);
        chk("mid_wcnt_after", a_wcnt, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
